// File: rtl/mux_serializer_if.sv
// Valid/ready bundle between a word producer, the serializer and a bit consumer.
// slave is the serializer's view; master is the producer/consumer view.
interface mux_serializer_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned S = $clog2(N);

    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [S-1:0] sel;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_valid,
        input  out_ready,
        output out_last,
        output sel
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  sel
    );
endinterface

// File: rtl/mux_serializer.sv
// Parallel-in / serial-out stage that owns the select of an N:1 mux.
// A word is captured on an input handshake. A select counter then walks all N bit
// positions, emitting one bit per accepted output beat. Because the input can reload
// on the final beat, consecutive words stream out without a gap.
// Build option: define SERIALIZER_MSB_FIRST_EN to emit MSB first. In that build sel
// counts down from N-1. In the default build it counts up from 0.

// N:1 mux: out is in[sel], purely combinational.
module mux_n #(
    parameter int unsigned N = 8,
    parameter int unsigned S = $clog2(N)
) (
    input  logic [N-1:0] in,
    input  logic [S-1:0] sel,
    output logic         out
);
    // Select one bit of the input word.
    always_comb begin
        out = in[sel];
    end
endmodule

module mux_serializer #(
    parameter int unsigned N = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux_serializer_if.slave bus
);
    localparam int unsigned S = $clog2(N);

`ifdef SERIALIZER_MSB_FIRST_EN
    localparam logic [S-1:0] FIRST = S'(N - 1);
    localparam logic [S-1:0] LAST  = '0;
`else
    localparam logic [S-1:0] FIRST = '0;
    localparam logic [S-1:0] LAST  = S'(N - 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t       state;
    logic [N-1:0] word;
    logic [S-1:0] sel_q;
    logic         valid_q;
    logic         last_q;

    logic [S-1:0] sel_step;
    logic         at_last;
    logic         mux_out;
    logic         in_ready_c;

    // Next select position in emission order.
    always_comb begin
`ifdef SERIALIZER_MSB_FIRST_EN
        sel_step = sel_q - S'(1);
`else
        sel_step = sel_q + S'(1);
`endif
        at_last = (sel_q == LAST);
    end

    // Bit source: captured word indexed by the select counter.
    mux_n #(
        .N (N),
        .S (S)
    ) u_mux (
        .in  (word),
        .sel (sel_q),
        .out (mux_out)
    );

    // Accept when idle, or on the final beat of the current word so the next word
    // follows with no bubble. This path is combinational from out_ready by design.
    always_comb begin
        in_ready_c = (state == IDLE) || (at_last && bus.out_ready);
    end

    // Control FSM: capture, step the select, reload or retire the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            word    <= '0;
            sel_q   <= FIRST;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word    <= bus.in_data;
                        sel_q   <= FIRST;
                        state   <= SHIFT;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.out_ready) begin
                        if (!at_last) begin
                            sel_q  <= sel_step;
                            last_q <= (sel_step == LAST);
                        end else if (bus.in_valid) begin
                            word   <= bus.in_data;
                            sel_q  <= FIRST;
                            last_q <= 1'b0;
                        end else begin
                            sel_q   <= FIRST;
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    sel_q   <= FIRST;
                end
            endcase
        end
    end

    // Drive the bus; out_bit is gated so it reads 0 whenever no beat is presented.
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = valid_q;
        bus.out_last  = last_q;
        bus.out_bit   = valid_q & mux_out;
        bus.sel       = sel_q;
    end

    // A stalled beat is frozen until the consumer takes it.
    a_stall_hold : assert property (@(posedge clk) disable iff (rst)
        (valid_q && !bus.out_ready) |=> (valid_q && $stable(sel_q) && $stable(word)));

    // out_last is a registered copy of the final-position decode.
    a_last_track : assert property (@(posedge clk) disable iff (rst)
        valid_q |-> (last_q == at_last));

    // The select rests on the first position whenever no word is in flight.
    a_idle_sel : assert property (@(posedge clk) disable iff (rst)
        !valid_q |-> (sel_q == FIRST));

    // out_valid mirrors the SHIFT state.
    a_valid_state : assert property (@(posedge clk) disable iff (rst)
        valid_q == (state == SHIFT));
endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: directed scenarios plus randomized traffic, each checked
// against a queue model of the bits still owed to the consumer.
module tb_mux_serializer;
`ifdef SERIALIZER_MSB_FIRST_EN
    localparam int unsigned N = 2;
`else
    localparam int unsigned N = 8;
`endif
    localparam int unsigned S = $clog2(N);
`ifdef SERIALIZER_MSB_FIRST_EN
    localparam logic [S-1:0] FIRST = S'(N - 1);
`else
    localparam logic [S-1:0] FIRST = '0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mux_serializer_if #(.N(N)) bus ();

    mux_serializer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: one entry per bit still to be emitted, front = bit currently presented.
    typedef struct {
        logic         b;
        logic         last;
        logic [S-1:0] pos;
    } beat_t;
    beat_t q[$];

    function automatic int unsigned pos_of(input int unsigned k);
`ifdef SERIALIZER_MSB_FIRST_EN
        return N - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic void push_word(input logic [N-1:0] w);
        for (int unsigned k = 0; k < N; k++) begin
            beat_t e;
            e.b    = w[pos_of(k)];
            e.last = (k == N - 1);
            e.pos  = S'(pos_of(k));
            q.push_back(e);
        end
    endfunction

    function automatic logic exp_valid();
        return q.size() != 0;
    endfunction

    function automatic logic exp_ready();
        return (q.size() == 0) || ((q.size() == 1) && bus.out_ready);
    endfunction

    function automatic logic [S+3:0] expv();
        if (q.size() == 0) return {1'b0, 1'b0, 1'b0, exp_ready(), FIRST};
        return {1'b1, q[0].b, q[0].last, exp_ready(), q[0].pos};
    endfunction

    function automatic logic [S+3:0] obs();
        return {bus.out_valid, bus.out_bit, bus.out_last, bus.in_ready, bus.sel};
    endfunction

    // Drive one cycle's inputs at the falling edge and let outputs settle.
    task automatic cycle(input logic r, input logic iv, input logic [N-1:0] d, input logic ordy);
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_advance();
        logic acc;
        logic bt;
        acc = bus.in_valid && exp_ready();
        bt  = exp_valid() && bus.out_ready;
        if (rst) begin
            q.delete();
        end else begin
            if (bt) void'(q.pop_front());
            if (acc) push_word(bus.in_data);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, N'($urandom), 1'b1);
            model_advance();
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (obs() !== {1'b0, 1'b0, 1'b0, 1'b1, FIRST}) begin
            n_fail++;
            $display("FAIL reset_state: got v/b/l/rdy/sel=%b want %b", obs(), {1'b0, 1'b0, 1'b0, 1'b1, FIRST});
        end
        model_advance();
    endtask

`ifdef SERIALIZER_MSB_FIRST_EN
    task automatic test_msb_n2();
        logic exp_b   [2] = '{1'b1, 1'b0};
        logic exp_sel [2] = '{1'b1, 1'b0};
        cycle(1'b0, 1'b1, 2'b10, 1'b1);
        model_advance();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 2'($urandom), 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== exp_b[k] || bus.sel !== exp_sel[k]
                || bus.out_last !== (k == 1)) begin
                n_fail++;
                $display("FAIL msb_n2 beat %0d: got v/b/sel/l=%b/%b/%b/%b want 1/%b/%b/%b",
                         k, bus.out_valid, bus.out_bit, bus.sel, bus.out_last, exp_b[k], exp_sel[k], k == 1);
            end
            model_advance();
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_n2_idle: got v/rdy=%b/%b want 0/1", bus.out_valid, bus.in_ready);
        end
        model_advance();
    endtask
`else
    task automatic test_basic();
        logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cycle(1'b0, 1'b1, 8'hA5, 1'b1);
        model_advance();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 8'($urandom), 1'b1);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL basic_model beat %0d: got %b want %b", k, obs(), expv());
            end
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== seq[k] || bus.out_last !== (k == 7)) begin
                n_fail++;
                $display("FAIL basic beat %0d: got v/b/l=%b/%b/%b want 1/%b/%b",
                         k, bus.out_valid, bus.out_bit, bus.out_last, seq[k], k == 7);
            end
            model_advance();
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got v/rdy/l=%b/%b/%b want 0/1/0", bus.out_valid, bus.in_ready, bus.out_last);
        end
        model_advance();
    endtask

    task automatic test_backpressure();
        int         b     = 0;
        int         stall = 0;
        logic       ordy;
        logic [7:0] got   = '0;
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        model_advance();
        for (int c = 0; c < 16 && b < 8; c++) begin
            ordy = !(b == 2 && stall < 3);
            cycle(1'b0, 1'b0, 8'($urandom), ordy);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL bp_model cyc %0d: got %b want %b", c, obs(), expv());
            end
            if (!ordy) begin
                stall++;
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.sel !== S'(2)) begin
                    n_fail++;
                    $display("FAIL bp_stall %0d: got v/b/sel=%b/%b/%0d want 1/1/2",
                             stall, bus.out_valid, bus.out_bit, bus.sel);
                end
            end
            if (bus.out_valid === 1'b1 && ordy) begin
                got[b] = bus.out_bit;
                b++;
            end
            model_advance();
        end
        n_checks++;
        if (got !== 8'h3C || b != 8 || stall != 3) begin
            n_fail++;
            $display("FAIL bp_stream: got word %h beats %0d stalls %0d want 3c/8/3", got, b, stall);
        end
    endtask

    task automatic test_back_to_back();
        logic taken = 1'b0;
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        model_advance();
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, !taken, taken ? 8'($urandom) : 8'h00, 1'b1);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL b2b_model beat %0d: got %b want %b", k, obs(), expv());
            end
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== (k < 8) || bus.in_ready !== (k == 7 || k == 15)) begin
                n_fail++;
                $display("FAIL b2b beat %0d: got v/b/rdy=%b/%b/%b want 1/%b/%b",
                         k, bus.out_valid, bus.out_bit, bus.in_ready, k < 8, k == 7 || k == 15);
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) taken = 1'b1;
            model_advance();
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: got v/rdy=%b/%b want 0/1", bus.out_valid, bus.in_ready);
        end
        model_advance();
    endtask

    task automatic test_reset_mid();
        logic [7:0] got = '0;
        cycle(1'b0, 1'b1, 8'hF0, 1'b1);
        model_advance();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'($urandom), 1'b1);
            model_advance();
        end
        cycle(1'b1, 1'b1, 8'hAA, 1'b1);
        model_advance();
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.sel !== S'(0) || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_state: got v/sel/rdy=%b/%0d/%b want 0/0/1", bus.out_valid, bus.sel, bus.in_ready);
        end
        model_advance();
        cycle(1'b0, 1'b1, 8'h01, 1'b1);
        model_advance();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 8'($urandom), 1'b1);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL rst_mid_model beat %0d: got %b want %b", k, obs(), expv());
            end
            got[k] = bus.out_bit;
            model_advance();
        end
        n_checks++;
        if (got !== 8'h01) begin
            n_fail++;
            $display("FAIL rst_mid_word: got %h want 01", got);
        end
    endtask

    task automatic test_isolation();
        logic [7:0] got = '0;
        cycle(1'b0, 1'b1, 8'h81, 1'b1);
        model_advance();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 8'($urandom), 1'b1);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL iso_model beat %0d: got %b want %b", k, obs(), expv());
            end
            got[k] = bus.out_bit;
            model_advance();
        end
        n_checks++;
        if (got !== 8'h81) begin
            n_fail++;
            $display("FAIL iso_word: got %h want 81", got);
        end
    endtask
`endif

    task automatic test_random();
        logic r;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 99) == 0);
            cycle(r, 1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 3) != 0));
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got v/b/l/rdy/sel=%b want %b", c, obs(), expv());
            end
            model_advance();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
`ifdef SERIALIZER_MSB_FIRST_EN
        test_msb_n2();
`else
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_isolation();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
